// File: rtl/mem_arb_pkg.sv
// Shared types for the data_mem arbiter: FSM state, AddrMode width and
// the packed request bundle {we, addr, wd, mode} steered onto data_mem.
package mem_arb_pkg;

  localparam int MODE_W = 3;
  localparam int REQ_AW = 32;
  localparam int REQ_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    CPU_OWN,
    DBG_OWN,
    DBG_LOCK
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wd;
    logic [MODE_W-1:0] mode;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_mux.sv
// Combinational request select: the granted requester's bundle, or all zero
// with no grant. Ports: cpu_gnt/dbg_gnt, cpu_r/dbg_r in, mem_r out.
module mem_arb_mux
  import mem_arb_pkg::*;
(
  input  logic     cpu_gnt,
  input  logic     dbg_gnt,
  input  mem_req_t cpu_r,
  input  mem_req_t dbg_r,
  output mem_req_t mem_r
);

  always_comb begin
    mem_r = '0;
    if (cpu_gnt) begin
      mem_r = cpu_r;
    end else if (dbg_gnt) begin
      mem_r = dbg_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data_mem arbiter: CPU load/store vs debug/loader master.
// Ports: clk/rst (sync, high); cpu_* request, cpu_gnt/cpu_stall;
// dbg_* request with dbg_lock bursts, dbg_gnt; mem_* to data_mem;
// mem_rd in, rdata out. MEM_ARB_STARVE_GUARD_EN enables the forced
// debug grant after MAX_WAIT CPU-won pending cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  input  logic [MODE_W-1:0]     cpu_mode,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_lock,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wd,
  input  logic [MODE_W-1:0]     dbg_mode,
  output logic                  dbg_gnt,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic [MODE_W-1:0]     mem_mode,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_t state_q, state_d;
  logic       starve;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign starve = dbg_req &&
                  (wait_cnt_q == CNT_W'(MAX_WAIT));

  // Counts cycles a pending debug request loses to the CPU.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (rst || dbg_gnt || !dbg_req) begin
      wait_cnt_d = '0;
    end else if (cpu_gnt &&
                 wait_cnt_q != CNT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  logic [CNT_W-1:0] wait_cnt;
  logic             unused_wait;

  assign wait_cnt    = '0;
  assign unused_wait = ^wait_cnt;
  assign starve      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      state_d = IDLE;
    end else if (state_q == DBG_LOCK) begin
      dbg_gnt = dbg_req;
      if (!dbg_req)     state_d = IDLE;
      else if (dbg_lock) state_d = DBG_LOCK;
      else              state_d = DBG_OWN;
    end else if (cpu_req && !starve) begin
      cpu_gnt = 1'b1;
      state_d = CPU_OWN;
    end else if (dbg_req) begin
      dbg_gnt = 1'b1;
      state_d = dbg_lock ? DBG_LOCK : DBG_OWN;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  mem_req_t cpu_r, dbg_r, mem_r;

  assign cpu_r = '{we:   cpu_we,
                   addr: REQ_AW'(cpu_addr),
                   wd:   REQ_DW'(cpu_wd),
                   mode: cpu_mode};
  assign dbg_r = '{we:   dbg_we,
                   addr: REQ_AW'(dbg_addr),
                   wd:   REQ_DW'(dbg_wd),
                   mode: dbg_mode};

  mem_arb_mux u_mux (
    .cpu_gnt (cpu_gnt),
    .dbg_gnt (dbg_gnt),
    .cpu_r   (cpu_r),
    .dbg_r   (dbg_r),
    .mem_r   (mem_r)
  );

  assign mem_we   = mem_r.we;
  assign mem_addr = ADDR_WIDTH'(mem_r.addr);
  assign mem_wd   = DATA_WIDTH'(mem_r.wd);
  assign mem_mode = mem_r.mode;
  assign rdata    = mem_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: rule-level model checked every
// cycle on the falling edge, plus literal scenario expectations.
module tb_mem_arbiter;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wd;
  logic [2:0]  cpu_mode;
  logic        cpu_gnt, cpu_stall;
  logic        dbg_req, dbg_lock, dbg_we;
  logic [31:0] dbg_addr, dbg_wd;
  logic [2:0]  dbg_mode;
  logic        dbg_gnt;
  logic [31:0] rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic [2:0]  mem_mode;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_WAIT   (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .cpu_mode  (cpu_mode),
    .cpu_gnt   (cpu_gnt),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_lock  (dbg_lock),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wd    (dbg_wd),
    .dbg_mode  (dbg_mode),
    .dbg_gnt   (dbg_gnt),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_mode  (mem_mode),
    .mem_rd    (mem_rd)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // data_mem stand-in driven by the DUT, and the bench's own reference copy
  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];

  assign mem_rd = dmem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[9:2]] <= mem_wd;
  end

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // Model: does debug currently own the port through a burst, and how many
  // consecutive cycles has debug been waiting behind CPU grants.
  bit          m_locked = 1'b0;
  int          m_pend   = 0;
  logic        e_cg = 1'b0, e_dg = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0;
  logic [2:0]  e_mode = '0;

  always @(negedge clk) begin
    if (run) begin
      e_cg = 1'b0;
      e_dg = 1'b0;
      if (!rst) begin
        if (m_locked) e_dg = dbg_req;
        else if (cpu_req &&
                 !(GUARD && dbg_req && m_pend >= MW))
          e_cg = 1'b1;
        else e_dg = dbg_req;
      end
      e_we = 1'b0; e_addr = '0; e_wd = '0; e_mode = '0;
      if (e_cg) begin
        e_we = cpu_we; e_addr = cpu_addr;
        e_wd = cpu_wd; e_mode = cpu_mode;
      end else if (e_dg) begin
        e_we = dbg_we; e_addr = dbg_addr;
        e_wd = dbg_wd; e_mode = dbg_mode;
      end
      chk("cpu_gnt", 64'(cpu_gnt), 64'(e_cg));
      chk("dbg_gnt", 64'(dbg_gnt), 64'(e_dg));
      chk("cpu_stall", 64'(cpu_stall),
          64'(cpu_req && !e_cg));
      chk("gnt_excl", 64'(cpu_gnt & dbg_gnt), 64'd0);
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wd", 64'(mem_wd), 64'(e_wd));
      chk("mem_mode", 64'(mem_mode), 64'(e_mode));
      if ((e_cg || e_dg) && !e_we)
        chk("rdata", 64'(rdata),
            64'(ref_mem[e_addr[9:2]]));
    end
  end

  always @(posedge clk) begin
    if (run) begin
      if (rst) begin
        m_locked = 1'b0;
        m_pend   = 0;
      end else begin
        if ((e_cg || e_dg) && e_we)
          ref_mem[e_addr[9:2]] = e_wd;
        m_locked = e_dg && dbg_lock;
        if (e_dg || !dbg_req) m_pend = 0;
        else if (e_cg && m_pend < MW) m_pend++;
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0;
    cpu_wd = '0; cpu_mode = '0;
    dbg_req = 0; dbg_lock = 0; dbg_we = 0;
    dbg_addr = '0; dbg_wd = '0; dbg_mode = '0;
  endtask

  task automatic cpu(input logic we, input logic [31:0] a,
                     input logic [31:0] d);
    cpu_req = 1; cpu_we = we; cpu_addr = a;
    cpu_wd = d; cpu_mode = 3'b010;
  endtask

  task automatic dbg(input logic we, input logic lk,
                     input logic [31:0] a, input logic [31:0] d);
    dbg_req = 1; dbg_lock = lk; dbg_we = we;
    dbg_addr = a; dbg_wd = d; dbg_mode = 3'b010;
  endtask

  int stalls;
  int gnt_at;

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    idle();
    rst = 1;
    cpu_req = 1;
    run = 1;
    #2;
    chk("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd1);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    go(); go();
    rst = 0;

    // CPU store then load back
    cpu(1, 32'h10, 32'hDEADBEEF);
    #2;
    chk("st_gnt", 64'(cpu_gnt), 64'd1);
    chk("st_we", 64'(mem_we), 64'd1);
    go();
    cpu(0, 32'h10, 32'h0);
    #2;
    chk("ld_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("ld_stall", 64'(cpu_stall), 64'd0);
    go();
    idle();
    go();

    // Simultaneous requests: CPU first, debug next cycle
    cpu(0, 32'h20, 32'h0);
    dbg(1, 0, 32'h30, 32'h12345678);
    #2;
    chk("sim_cpu", 64'(cpu_gnt), 64'd1);
    chk("sim_dbg0", 64'(dbg_gnt), 64'd0);
    go();
    cpu_req = 0;
    #2;
    chk("sim_dbg1", 64'(dbg_gnt), 64'd1);
    go();
    idle();
    cpu(0, 32'h30, 32'h0);
    #2;
    chk("sim_rd", 64'(rdata), 64'h12345678);
    go();
    idle();
    go();

    // Burst: lock beat with CPU idle, then 3 beats with CPU waiting
    dbg(1, 1, 32'hFC, 32'hA0);
    go();
    cpu(0, 32'h40, 32'h0);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      dbg(1, (i < 2), 32'h100 + 32'(4 * i), 32'hB0 + 32'(i));
      #2;
      if (cpu_stall) stalls++;
      go();
    end
    dbg_req = 0; dbg_lock = 0;
    #2;
    chk("burst_cpu4", 64'(cpu_gnt), 64'd1);
    chk("burst_stalls", 64'(stalls), 64'd3);
    go();
    cpu(0, 32'h104, 32'h0);
    #2;
    chk("burst_rd", 64'(rdata), 64'hB1);
    go();
    idle();
    go();

    // Reset on beat 2 of a locked burst
    dbg(1, 1, 32'h80, 32'h11);
    go();
    dbg(1, 1, 32'h84, 32'h22);
    cpu(0, 32'h10, 32'h0);
    rst = 1;
    #2;
    chk("mrst_dbg", 64'(dbg_gnt), 64'd0);
    chk("mrst_cpu", 64'(cpu_gnt), 64'd0);
    chk("mrst_we", 64'(mem_we), 64'd0);
    go();
    rst = 0;
    #2;
    chk("mrst_cpu_after", 64'(cpu_gnt), 64'd1);
    go();
    idle();
    go();

    // Debug pending while CPU accesses every cycle
    cpu(0, 32'h10, 32'h0);
    dbg(1, 0, 32'h200, 32'h55);
    gnt_at = 0;
    stalls = 0;
    for (int k = 1; k <= 50; k++) begin
      #2;
      if (cpu_stall) stalls++;
      if (dbg_gnt && gnt_at == 0) gnt_at = k;
      go();
      if (gnt_at != 0) break;
    end
    dbg_req = 0;
    #2;
    chk("starve_cpu_back", 64'(cpu_gnt), 64'd1);
    if (GUARD) begin
      chk("starve_gnt_at", 64'(gnt_at), 64'd9);
      chk("starve_stalls", 64'(stalls), 64'd1);
    end else begin
      chk("starve_gnt_at", 64'(gnt_at), 64'd0);
      chk("starve_stalls", 64'(stalls), 64'd0);
    end
    go();
    idle();
    go(); go();

    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter that shares `data_mem` between the CPU load/store path and a debug/loader master. It sits between the core's ALU-address/RD2 datapath and `data_mem`, owns the memory address, write-data, write-enable and AddrMode inputs, and stalls the CPU with `cpu_stall` when the debug master holds the port. Read data returns to the granted requester in the same cycle. Debug bursts and a starvation guard are sequenced by a small FSM.

## Interface
- `ADDR_WIDTH`, 32, address width of both requesters and memory
- `DATA_WIDTH`, 32, data width
- `MAX_WAIT`, 8, CPU-won cycles a pending debug request tolerates before a forced grant (starvation guard only)
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU load/store this cycle
- `cpu_we`  in  1  CPU store
- `cpu_addr`  in  ADDR_WIDTH  CPU address (ALU result)
- `cpu_wd`  in  DATA_WIDTH  CPU store data
- `cpu_mode`  in  3  CPU AddrMode
- `cpu_gnt`  out  1  CPU access performed this cycle
- `cpu_stall`  out  1  equals `cpu_req & ~cpu_gnt`; holds PC and blocks RegWrite
- `dbg_req`  in  1  debug access request
- `dbg_lock`  in  1  keep ownership after this beat (burst)
- `dbg_we`, `dbg_addr`, `dbg_wd`, `dbg_mode`  in  1/ADDR_WIDTH/DATA_WIDTH/3  debug access fields
- `dbg_gnt`  out  1  debug access performed this cycle
- `rdata`  out  DATA_WIDTH  `mem_rd` pass-through, valid in the granted cycle only
- `mem_we`, `mem_addr`, `mem_wd`, `mem_mode`  out  1/ADDR_WIDTH/DATA_WIDTH/3  to `data_mem`
- `mem_rd`  in  DATA_WIDTH  from `data_mem` (combinational read)

## Operation
- FSM states: IDLE, CPU_OWN, DBG_OWN, DBG_LOCK. Only `state` and `wait_cnt` are registered; grants are combinational from `state`, the requests and `wait_cnt`.
- IDLE/CPU_OWN/DBG_OWN: CPU has fixed priority. If `cpu_req`, grant CPU and go to CPU_OWN. If only `dbg_req`, grant debug and go to DBG_OWN, or to DBG_LOCK if `dbg_lock`=1. If neither requests, go to IDLE.
- DBG_LOCK: only debug is granted. `cpu_stall`=1 whenever `cpu_req`=1. Stay in DBG_LOCK while `dbg_req & dbg_lock`. On the first `dbg_req & ~dbg_lock` beat, grant it and go to DBG_OWN. If `dbg_req`=0, grant nothing and go to IDLE.
- Mux: `mem_*` carry the granted requester's fields. With no grant, `mem_we`=0, `mem_addr`=0, `mem_wd`=0 and `mem_mode`=0, so the memory is never written.
- `cpu_gnt & dbg_gnt` is never 1.
- Writes commit at the memory's clock edge in the grant cycle. `rdata` is meaningful only in the same cycle as the grant.

## Timing
- Reset: `state`=IDLE, `wait_cnt`=0. While `rst`=1: all grants 0, `mem_we`=0, `cpu_stall`=`cpu_req`.
- Grant latency is 0 cycles: the grant is in the request cycle when the port is free.
- A stalled CPU must hold `cpu_req`, `cpu_addr`, `cpu_wd` and `cpu_mode` stable until `cpu_gnt`.
- Debug holds its fields until `dbg_gnt`. Dropping `dbg_req` while ungranted is legal; no access occurs.
- A burst of N beats occupies N consecutive cycles. The CPU resumes in the cycle after the unlocking beat.
- Reset mid-burst: the lock is abandoned and the FSM is in IDLE the next cycle.
- `wait_cnt` saturates at `MAX_WAIT` and never wraps.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - `wait_cnt` increments each cycle with `dbg_req & cpu_gnt`, and clears on `dbg_gnt` or when `dbg_req`=0.
  - When `wait_cnt`==`MAX_WAIT` and both request, debug wins and the CPU stalls one cycle.
- Undefined: `wait_cnt` is absent (tied to 0) and CPU priority is absolute, so a CPU that accesses memory every cycle can starve debug indefinitely.

## Structure
- Package `mem_arb_pkg`: state enum `arb_state_t` (IDLE, CPU_OWN, DBG_OWN, DBG_LOCK), the AddrMode width constant, and a packed `mem_req_t` {we, addr, wd, mode}.
- Sub-module `mem_arb_mux`: purely combinational selection of `mem_req_t` by grant, with zeroed output when no grant. The FSM and counter stay in the top.
- The core integrates it by routing ALUout/RD2/AddrMode to the `cpu_*` ports and `cpu_stall` into `program_counter` and the RegWrite gating.

## Test plan
- Reset then CPU-only store: `cpu_req`=1, `cpu_we`=1, addr 0x10, wd 0xDEADBEEF → `cpu_gnt`=1 same cycle, `mem_we`=1; a CPU load of 0x10 next cycle gives `rdata`=0xDEADBEEF with `cpu_stall`=0.
- Simultaneous single requests: CPU load 0x20 and debug store 0x30 both asserted → CPU granted first; debug granted in the cycle after CPU drops its request; never both grants.
- Debug burst: debug writes 0x100, 0x104, 0x108 with `dbg_lock`=1,1,0 while `cpu_req`=1 → `cpu_stall`=1 for exactly 3 cycles; CPU granted in cycle 4.
- Reset mid-burst: assert `rst` on beat 2 of a locked burst → grants 0 while in reset; after release, CPU request granted immediately.
- With `MEM_ARB_STARVE_GUARD_EN` and `MAX_WAIT`=8: CPU requests every cycle and debug is pending → debug granted on the 9th pending cycle, `cpu_stall` for 1 cycle, `wait_cnt` back to 0.
- Without the macro, same stimulus for 50 cycles → `dbg_gnt` stays 0 throughout.
